// File: rtl/seg_scan_driver.sv
// Two-bank 4-digit 7-segment scanner with frame-coherent shadowing and edit-digit blink.
// Latency: outputs are registered, one cycle behind the internal digit index and shadow state.
// Backpressure: none; free-running display sink that samples its inputs every cycle.
module seg_scan_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [19:0] time_data,
    input  logic [5:0]  state_info,
    input  logic        edit_en,
    input  logic [2:0]  edit_bit,
    output logic [6:0]  led0,
    output logic [6:0]  led1,
    output logic [3:0]  led_mux0,
    output logic [3:0]  led_mux1,
    output logic        dp0,
    output logic        dp1
);

    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    // BCD digit to {g,f,e,d,c,b,a}; anything above 9 is blanked
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic          load_pend_q, load_pend_d;
    logic [19:0]   shd_time_q, shd_time_d;
    logic [5:0]    shd_state_q, shd_state_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_ph_q, blink_ph_d;
    logic [6:0]    led0_q, led0_d;
    logic [6:0]    led1_q, led1_d;
    logic [3:0]    mux_q, mux_d;
    logic          dp0_q, dp0_d;
    logic          dp1_q, dp1_d;

    logic          scan_tc;
    logic          frame_wrap;
    logic [3:0]    dig0;
    logic [3:0]    dig1;
    logic          blink_on;
    logic          blank0;
    logic          blank1;

    // Scan timing, frame-boundary shadow capture and blink phase
    always_comb begin
        scan_tc     = (scan_cnt_q == SCAN_LAST);
        frame_wrap  = scan_tc && (idx_q == 2'd3);

        scan_cnt_d  = scan_tc ? '0 : scan_cnt_q + 1'b1;
        idx_d       = scan_tc ? idx_q + 2'd1 : idx_q;

        // The very first post-reset cycle loads immediately so the first
        // frame does not have to display the cleared shadow for a whole frame
        load_pend_d = 1'b0;
        shd_time_d  = shd_time_q;
        shd_state_d = shd_state_q;
        if (load_pend_q || frame_wrap) begin
            shd_time_d  = time_data;
            shd_state_d = state_info;
        end

        // Leaving edit mode parks the blink at the visible phase so the next
        // edit always starts with a full visible half-period
        blink_cnt_d = '0;
        blink_ph_d  = 1'b0;
        if (edit_en) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                blink_ph_d  = blink_ph_q;
            end
        end
    end

    // Digit selection, decode, status blanking and blink masking for the output stage
    always_comb begin
        dig0 = 4'd0;
        dig1 = 4'd0;
        case (idx_q)
            2'd0: begin
                dig0 = shd_time_q[3:0];
                dig1 = shd_time_q[17:14];
            end
            2'd1: begin
                dig0 = {1'b0, shd_time_q[6:4]};
                dig1 = {2'b00, shd_time_q[19:18]};
            end
            2'd2: begin
                dig0 = shd_time_q[10:7];
                dig1 = {1'b0, shd_state_q[2:0]};
            end
            default: begin
                dig0 = {1'b0, shd_time_q[13:11]};
                dig1 = {1'b0, shd_state_q[5:3]};
            end
        endcase

        // edit_bit 0..3 maps onto bank0 digits, 4..5 onto bank1 digits 0..1
        blink_on = edit_en && blink_ph_q;
        blank0   = blink_on && (edit_bit == {1'b0, idx_q});
        blank1   = blink_on && (edit_bit == {1'b1, idx_q}) && !idx_q[1];

        led0_d = blank0 ? 7'd0 : seg7(dig0);
        led1_d = seg7(dig1);
        if (blank1 || (idx_q[1] && (shd_state_q == 6'd0))) begin
            led1_d = 7'd0;
        end

        mux_d = 4'b0001 << idx_q;
        dp0_d = (idx_q == 2'd2);
        dp1_d = (idx_q == 2'd0);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            scan_cnt_q  <= '0;
            idx_q       <= 2'd0;
            load_pend_q <= 1'b1;
            shd_time_q  <= 20'd0;
            shd_state_q <= 6'd0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            led0_q      <= 7'd0;
            led1_q      <= 7'd0;
            mux_q       <= 4'd0;
            dp0_q       <= 1'b0;
            dp1_q       <= 1'b0;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            load_pend_q <= load_pend_d;
            shd_time_q  <= shd_time_d;
            shd_state_q <= shd_state_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            led0_q      <= led0_d;
            led1_q      <= led1_d;
            mux_q       <= mux_d;
            dp0_q       <= dp0_d;
            dp1_q       <= dp1_d;
        end
    end

    assign led0     = led0_q;
    assign led1     = led1_q;
    assign led_mux0 = mux_q;
    assign led_mux1 = mux_q;
    assign dp0      = dp0_q;
    assign dp1      = dp1_q;

endmodule
